fby4_period_monitor: RTL and testbench

//  Consumer stage for the divide-by-4 output. Samples the divided signal in the

---
 rtl/fby4_period_monitor.sv | 179 +++++++++++++++++
 tb/tb_fby4_period_monitor.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fby4_period_monitor.sv
// rtl/fby4_period_monitor.sv - period/high-time monitor for the divide-by-4 output
//
// Ports:
//   clk          system clock, all logic on posedge
//   rst          asynchronous reset, active-low
//   q_in         divided clock being monitored (asynchronous to clk)
//   clr          synchronous clear of the statistics, active-high
//   rise_tick    one-cycle pulse per detected rising edge of q_in
//   fall_tick    one-cycle pulse per detected falling edge of q_in
//   period       last measured period in clk cycles (rise to rise)
//   high_time    last measured high time in clk cycles (rise to fall)
//   period_valid one-cycle pulse when period is updated
//   period_cnt   completed periods since reset/clr, wraps
//   stalled      level, set when no edge has been seen for TIMEOUT cycles
module fby4_period_monitor #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16,
  parameter int PCNT_W      = 16,
  parameter int TIMEOUT     = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              q_in,
  input  logic              clr,
  output logic              rise_tick,
  output logic              fall_tick,
  output logic [CNT_W-1:0]  period,
  output logic [CNT_W-1:0]  high_time,
  output logic              period_valid,
  output logic [PCNT_W-1:0] period_cnt,
  output logic              stalled
);

  typedef enum logic {
    WAIT_FIRST = 1'b0,
    MEASURE    = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   q_d_q, q_d_d;
  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cyc_q, cyc_d;
  logic [CNT_W-1:0]       idle_q, idle_d;
  logic [CNT_W-1:0]       period_q, period_d;
  logic [CNT_W-1:0]       high_time_q, high_time_d;
  logic                   period_valid_q, period_valid_d;
  logic [PCNT_W-1:0]      period_cnt_q, period_cnt_d;
  logic                   stalled_q, stalled_d;
  logic                   rise_tick_q, rise_tick_d;
  logic                   fall_tick_q, fall_tick_d;

  logic q_s;
  logic rise;
  logic fall;
  logic any_edge;

  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], q_in};
    q_s      = sync_q[SYNC_STAGES-1];
    q_d_d    = q_s;
    rise     = q_s & ~q_d_q;
    fall     = ~q_s & q_d_q;
    any_edge = rise | fall;

    // Ticks come straight from edge detection; clr deliberately has no effect here.
    rise_tick_d = rise;
    fall_tick_d = fall;

    // Cycles since the last rise, saturating so a stuck input cannot wrap it.
    if (rise) begin
      cyc_d = CNT_W'(1);
    end else if (cyc_q == CNT_MAX) begin
      cyc_d = cyc_q;
    end else begin
      cyc_d = cyc_q + 1'b1;
    end

    // Cycles since the last edge of either polarity, saturating.
    if (any_edge) begin
      idle_d = '0;
    end else if (idle_q == CNT_MAX) begin
      idle_d = idle_q;
    end else begin
      idle_d = idle_q + 1'b1;
    end

    state_d        = state_q;
    period_d       = period_q;
    high_time_d    = high_time_q;
    period_valid_d = 1'b0;
    period_cnt_d   = period_cnt_q;
    stalled_d      = stalled_q;

    if (any_edge) begin
      stalled_d = 1'b0;
    end

    case (state_q)
      WAIT_FIRST: begin
        // First rise only establishes the reference; a lone fall is ignored.
        if (rise) begin
          state_d = MEASURE;
        end
      end
      MEASURE: begin
        if (rise) begin
          period_d       = cyc_q;
          period_valid_d = 1'b1;
          period_cnt_d   = period_cnt_q + 1'b1;
        end
        if (fall) begin
          high_time_d = cyc_q;
        end
      end
      default: state_d = WAIT_FIRST;
    endcase

    // Equality rather than >= so the timeout fires once; stalled then holds
    // until the next edge while period/high_time keep their last values.
    if (!any_edge && (idle_d == TIMEOUT_C)) begin
      stalled_d = 1'b1;
      state_d   = WAIT_FIRST;
    end

    // clr wins over a coincident rise. The idle timer restarts too so that a
    // divider still stuck after the clear is flagged again.
    if (clr) begin
      state_d        = WAIT_FIRST;
      period_d       = '0;
      high_time_d    = '0;
      period_valid_d = 1'b0;
      period_cnt_d   = '0;
      stalled_d      = 1'b0;
      idle_d         = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q         <= '0;
      q_d_q          <= 1'b0;
      state_q        <= WAIT_FIRST;
      cyc_q          <= '0;
      idle_q         <= '0;
      period_q       <= '0;
      high_time_q    <= '0;
      period_valid_q <= 1'b0;
      period_cnt_q   <= '0;
      stalled_q      <= 1'b0;
      rise_tick_q    <= 1'b0;
      fall_tick_q    <= 1'b0;
    end else begin
      sync_q         <= sync_d;
      q_d_q          <= q_d_d;
      state_q        <= state_d;
      cyc_q          <= cyc_d;
      idle_q         <= idle_d;
      period_q       <= period_d;
      high_time_q    <= high_time_d;
      period_valid_q <= period_valid_d;
      period_cnt_q   <= period_cnt_d;
      stalled_q      <= stalled_d;
      rise_tick_q    <= rise_tick_d;
      fall_tick_q    <= fall_tick_d;
    end
  end

  assign rise_tick    = rise_tick_q;
  assign fall_tick    = fall_tick_q;
  assign period       = period_q;
  assign high_time    = high_time_q;
  assign period_valid = period_valid_q;
  assign period_cnt   = period_cnt_q;
  assign stalled      = stalled_q;

endmodule

// File: tb/tb_fby4_period_monitor.sv
// tb/tb_fby4_period_monitor.sv - directed self-checking bench for fby4_period_monitor
module tb_fby4_period_monitor;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        q_in = 1'b0;
  logic        clr = 1'b0;

  logic        rise_tick, fall_tick, period_valid, stalled;
  logic [15:0] period, high_time, period_cnt;

  logic        rise_tick4, fall_tick4, period_valid4, stalled4;
  logic [15:0] period4, high_time4;
  logic [3:0]  period_cnt4;

  int errors = 0;
  int checks = 0;
  int ncyc   = 0;

  always #5 clk = ~clk;

  fby4_period_monitor dut (
    .clk(clk), .rst(rst), .q_in(q_in), .clr(clr),
    .rise_tick(rise_tick), .fall_tick(fall_tick),
    .period(period), .high_time(high_time),
    .period_valid(period_valid), .period_cnt(period_cnt),
    .stalled(stalled)
  );

  fby4_period_monitor #(.PCNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .q_in(q_in), .clr(clr),
    .rise_tick(rise_tick4), .fall_tick(fall_tick4),
    .period(period4), .high_time(high_time4),
    .period_valid(period_valid4), .period_cnt(period_cnt4),
    .stalled(stalled4)
  );

  // One clock cycle: drive inputs after posedge, return at the following negedge.
  task automatic cyc1(input logic v, input logic c);
    @(posedge clk);
    #1 q_in = v;
    clr = c;
    @(negedge clk);
    ncyc++;
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    q_in = 1'b0;
    clr = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({rise_tick, fall_tick, period_valid, stalled} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 0000", {rise_tick, fall_tick, period_valid, stalled});
    end
    checks++;
    if (period !== 16'd0 || high_time !== 16'd0) begin
      errors++;
      $display("FAIL reset_meas: got period=%0d high=%0d expected 0/0", period, high_time);
    end
    checks++;
    if (period_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_cnt: got %0d expected 0", period_cnt);
    end
  endtask

  task automatic run_fby4_checks(input int nper);
    int rises = 0;
    int last_rise = -1;
    int pvs = 0;
    for (int p = 0; p < nper; p++) begin
      for (int i = 0; i < 4; i++) begin
        cyc1(i < 2, 1'b0);
        if (rise_tick === 1'b1) begin
          if (last_rise >= 0) begin
            checks++;
            if (ncyc - last_rise != 4) begin
              errors++;
              $display("FAIL fby4_rise_gap: got %0d expected 4", ncyc - last_rise);
            end
          end
          rises++;
          last_rise = ncyc;
        end
        if (period_valid === 1'b1) begin
          pvs++;
          checks++;
          if (rises != pvs + 1) begin
            errors++;
            $display("FAIL fby4_valid_on_rise: got rise %0d expected rise %0d", rises, pvs + 1);
          end
          checks++;
          if (period !== 16'd4 || high_time !== 16'd2) begin
            errors++;
            $display("FAIL fby4_meas: got period=%0d high=%0d expected 4/2", period, high_time);
          end
          checks++;
          if (period_cnt !== 16'(pvs)) begin
            errors++;
            $display("FAIL fby4_cnt: got %0d expected %0d", period_cnt, pvs);
          end
        end
      end
    end
    checks++;
    if (rises != nper || pvs != nper - 1) begin
      errors++;
      $display("FAIL fby4_totals: got rises=%0d valids=%0d expected %0d/%0d", rises, pvs, nper, nper - 1);
    end
  endtask

  task automatic test_fby4();
    apply_reset();
    run_fby4_checks(6);
  endtask

  task automatic test_3h7l();
    int last_rise = -1;
    int pvs = 0;
    apply_reset();
    for (int p = 0; p < 5; p++) begin
      for (int i = 0; i < 10; i++) begin
        cyc1(i < 3, 1'b0);
        if (rise_tick === 1'b1) last_rise = ncyc;
        if (fall_tick === 1'b1 && last_rise >= 0) begin
          checks++;
          if (ncyc - last_rise != 3) begin
            errors++;
            $display("FAIL 3h7l_fall_gap: got %0d expected 3", ncyc - last_rise);
          end
        end
        if (period_valid === 1'b1) begin
          pvs++;
          checks++;
          if (period !== 16'd10 || high_time !== 16'd3) begin
            errors++;
            $display("FAIL 3h7l_meas: got period=%0d high=%0d expected 10/3", period, high_time);
          end
        end
      end
    end
    checks++;
    if (pvs != 4) begin
      errors++;
      $display("FAIL 3h7l_valids: got %0d expected 4", pvs);
    end
  endtask

  task automatic test_stall();
    int last_fall = -1;
    int first_stall = -1;
    int nr = 0;
    apply_reset();
    for (int p = 0; p < 3; p++)
      for (int i = 0; i < 4; i++) begin
        cyc1(i < 2, 1'b0);
        if (fall_tick === 1'b1) last_fall = ncyc;
      end
    for (int n = 0; n < 1100; n++) begin
      cyc1(1'b0, 1'b0);
      if (fall_tick === 1'b1) last_fall = ncyc;
      if (stalled === 1'b1 && first_stall < 0) first_stall = ncyc;
    end
    checks++;
    if (first_stall < 0 || first_stall - last_fall != 1024) begin
      errors++;
      $display("FAIL stall_time: got %0d expected 1024", first_stall - last_fall);
    end
    checks++;
    if (period !== 16'd4 || high_time !== 16'd2) begin
      errors++;
      $display("FAIL stall_hold: got period=%0d high=%0d expected 4/2", period, high_time);
    end
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < 4; i++) begin
        cyc1(i < 2, 1'b0);
        if (rise_tick === 1'b1) begin
          nr++;
          if (nr == 1) begin
            checks++;
            if (stalled !== 1'b0 || period_valid !== 1'b0) begin
              errors++;
              $display("FAIL stall_restart: got stalled=%b valid=%b expected 0/0", stalled, period_valid);
            end
          end else if (nr == 2) begin
            checks++;
            if (period_valid !== 1'b1 || period !== 16'd4) begin
              errors++;
              $display("FAIL stall_resume: got valid=%b period=%0d expected 1/4", period_valid, period);
            end
          end
        end
      end
    checks++;
    if (nr != 2) begin
      errors++;
      $display("FAIL stall_rises: got %0d expected 2", nr);
    end
  endtask

  task automatic test_clr_rise();
    apply_reset();
    for (int p = 0; p < 6; p++)
      for (int i = 0; i < 4; i++) begin
        cyc1(i < 2, (p == 3) && (i == 2));
        if (i == 3 && p == 3) begin
          checks++;
          if (rise_tick !== 1'b1 || period_valid !== 1'b0 || period_cnt !== 16'd0 || period !== 16'd0) begin
            errors++;
            $display("FAIL clr_rise: got tick=%b valid=%b cnt=%0d period=%0d expected 1/0/0/0",
                     rise_tick, period_valid, period_cnt, period);
          end
        end
        if (i == 3 && p == 4) begin
          checks++;
          if (rise_tick !== 1'b1 || period_valid !== 1'b0) begin
            errors++;
            $display("FAIL clr_next_rise: got tick=%b valid=%b expected 1/0", rise_tick, period_valid);
          end
        end
        if (i == 3 && p == 5) begin
          checks++;
          if (period_valid !== 1'b1 || period !== 16'd4 || period_cnt !== 16'd1) begin
            errors++;
            $display("FAIL clr_resume: got valid=%b period=%0d cnt=%0d expected 1/4/1",
                     period_valid, period, period_cnt);
          end
        end
      end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    for (int p = 0; p < 3; p++)
      for (int i = 0; i < 4; i++) cyc1(i < 2, 1'b0);
    cyc1(1'b1, 1'b0);
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({rise_tick, fall_tick, period_valid, stalled} !== 4'b0000 ||
        period !== 16'd0 || high_time !== 16'd0 || period_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_mid: got flags=%b period=%0d high=%0d cnt=%0d expected all 0",
               {rise_tick, fall_tick, period_valid, stalled}, period, high_time, period_cnt);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    q_in = 1'b0;
    @(negedge clk);
    run_fby4_checks(5);
  endtask

  task automatic test_wrap();
    int pvs = 0;
    apply_reset();
    for (int p = 0; p < 19; p++)
      for (int i = 0; i < 4; i++) begin
        cyc1(i < 2, 1'b0);
        if (period_valid4 === 1'b1) begin
          pvs++;
          checks++;
          if (period_cnt4 !== 4'(pvs)) begin
            errors++;
            $display("FAIL wrap_cnt: got %0d expected %0d", period_cnt4, pvs % 16);
          end
          if (pvs == 15) begin
            checks++;
            if (period_cnt4 !== 4'd15) begin
              errors++;
              $display("FAIL wrap_15: got %0d expected 15", period_cnt4);
            end
          end
          if (pvs == 16) begin
            checks++;
            if (period_cnt4 !== 4'd0 || period_cnt !== 16'd16) begin
              errors++;
              $display("FAIL wrap_0: got %0d/%0d expected 0/16", period_cnt4, period_cnt);
            end
          end
        end
      end
    checks++;
    if (pvs != 18) begin
      errors++;
      $display("FAIL wrap_valids: got %0d expected 18", pvs);
    end
  endtask

  initial begin
    test_reset();
    test_fby4();
    test_3h7l();
    test_stall();
    test_clr_rise();
    test_reset_mid();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
